// File: rtl/io_pkg.sv
// Shared constants for the key/switch input peripheral: register offsets
// within the block and the base addresses the system top decodes against.
package io_pkg;

    localparam logic [1:0] REG_STATUS = 2'd0;
    localparam logic [1:0] REG_EVENTS = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;
    localparam logic [1:0] REG_SWITCH = 2'd3;

    localparam logic [31:0] IO_BASE_ADDR = 32'hFF20_0000;
    localparam logic [31:0] IO_KEYS_ADDR = IO_BASE_ADDR + 32'h0000_0050;
    localparam logic [31:0] IO_ADDR_MASK = 32'hFFFF_FFF0;

endpackage

// File: rtl/debounce_cell.sv
// One input bit: two-flop synchroniser followed by a stability counter that
// only accepts a new level after DEBOUNCE_CYCLES consecutive differing samples.
module debounce_cell #(
    parameter int   DEBOUNCE_CYCLES = 4,
    parameter logic RESET_VAL       = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic stable
);

    localparam logic [7:0] CNT_MAX = 8'(DEBOUNCE_CYCLES - 1);

    logic       s1;
    logic       s2;
    logic [7:0] cnt;

    // Sync flops reset to the idle level so releasing reset never looks like an edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1     <= RESET_VAL;
            s2     <= RESET_VAL;
            stable <= RESET_VAL;
            cnt    <= '0;
        end else begin
            s1 <= din;
            s2 <= s1;
            if (s2 == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                stable <= s2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 8'd1;
            end
        end
    end

endmodule

// File: rtl/io_key_events.sv
// Memory-mapped key/switch peripheral: debounced levels, latched press events
// with write-1-to-clear, a 16-bit press counter and a combinational read mux.
module io_key_events
    import io_pkg::*;
#(
    parameter int N_KEYS          = 4,
    parameter int N_SW            = 10,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_KEYS-1:0] key_raw,
    input  logic [N_SW-1:0]   sw_raw,
    input  logic              sel,
    input  logic              we,
    input  logic [1:0]        reg_off,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              event_pending
);

    logic [N_KEYS-1:0] stable_keys;
    logic [N_KEYS-1:0] key_level;
    logic [N_KEYS-1:0] key_level_q;
    logic [N_KEYS-1:0] press;
    logic [N_KEYS-1:0] events;
    logic [N_SW-1:0]   sw_level;
    logic [15:0]       count;
    logic [15:0]       count_base;
    logic [15:0]       press_cnt;
    logic              wr;
    logic              unused_wdata;

    genvar i;
    generate
        for (i = 0; i < N_KEYS; i++) begin : gen_keys
            debounce_cell #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
                .RESET_VAL      (1'b1)
            ) u_key (
                .clk   (clk),
                .reset (reset),
                .din   (key_raw[i]),
                .stable(stable_keys[i])
            );
        end
        for (i = 0; i < N_SW; i++) begin : gen_sw
            debounce_cell #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
                .RESET_VAL      (1'b0)
            ) u_sw (
                .clk   (clk),
                .reset (reset),
                .din   (sw_raw[i]),
                .stable(sw_level[i])
            );
        end
    endgenerate

    assign key_level     = ~stable_keys;
    assign press         = key_level & ~key_level_q;
    assign wr            = sel & we;
    assign event_pending = |events;
    assign unused_wdata  = ^wdata[31:16];

    always_comb begin
        press_cnt = '0;
        for (int k = 0; k < N_KEYS; k++) begin
            press_cnt = press_cnt + 16'(press[k]);
        end
    end

    // A load and a press landing together both count, so the press adds onto the loaded value.
    assign count_base = (wr && reg_off == REG_COUNT) ? wdata[15:0] : count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            key_level_q <= '0;
            events      <= '0;
            count       <= '0;
        end else begin
            key_level_q <= key_level;
            if (wr && reg_off == REG_EVENTS) begin
                events <= (events & ~wdata[N_KEYS-1:0]) | press;
            end else begin
                events <= events | press;
            end
            count <= count_base + press_cnt;
        end
    end

    always_comb begin
        rdata = '0;
        if (sel) begin
            case (reg_off)
                REG_STATUS: rdata[N_KEYS-1:0] = key_level;
                REG_EVENTS: rdata[N_KEYS-1:0] = events;
                REG_COUNT:  rdata[15:0]       = count;
                default:    rdata[N_SW-1:0]   = sw_level;
            endcase
        end
    end

endmodule

// File: doc/io_key_events.md
Name: io_key_events

Overview:
- Memory-mapped input peripheral upstream of the CPU's I/O read mux. It feeds debounced KEY/SW state and latched key-press events to the readdata path.
- Synchronises and debounces raw board inputs, counts presses, and exposes four word registers selected by a 2-bit offset.
- Lets software poll presses without missing short events at the slow core clock.

Parameters:
- N_KEYS, 4, number of active-low push buttons.
- N_SW, 10, number of slide switches.
- DEBOUNCE_CYCLES, 4, consecutive stable cycles (after sync) required to accept a new level; legal range 1..255.

Ports:
- clk  input  1  core clock (same clock as the CPU).
- reset  input  1  asynchronous reset, active-low (asserted when 0).
- key_raw  input  N_KEYS  raw buttons, 0 = pressed.
- sw_raw  input  N_SW  raw switches, 1 = on.
- sel  input  1  access targets this block (decoded by the top).
- we  input  1  write strobe, qualified by sel.
- reg_off  input  2  register select: 0 STATUS, 1 EVENTS, 2 COUNT, 3 SWITCH.
- wdata  input  32  write data.
- rdata  output  32  read data, combinational from registers and reg_off; 0 when sel=0.
- event_pending  output  1  OR of all EVENTS bits.

Behaviour:
- Reset (async, while reset=0):
  - key sync flops = 1 (released); switch sync flops = 0.
  - Debounce counters = 0; key_level = 0; sw_level = 0.
  - EVENTS = 0; COUNT = 0; event_pending = 0.
- Synchroniser: two flops per input bit, no reset-release glitch.
- Debounce, per bit:
  - s2 is the synchronised value; stable is the accepted value.
  - If s2 == stable: cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: stable <= s2, cnt <= 0.
  - Else: cnt <= cnt+1.
- Latency: a clean raw change is visible in stable exactly DEBOUNCE_CYCLES+2 rising edges after the raw change is first sampled. A bounce shorter than DEBOUNCE_CYCLES post-sync cycles never changes stable.
- key_level = ~stable_keys (1 = pressed).
- Press event on bit i: key_level[i] 0->1 in a cycle. Releases generate no events.
- EVENTS register, per bit:
  - Set on a press event.
  - Write-1-to-clear when sel & we & reg_off==1.
  - Set and clear in the same cycle: set wins (bit stays 1).
- COUNT register:
  - 16-bit, increments by the popcount of press events in the cycle (0..N_KEYS).
  - Wraps modulo 2^16.
  - Any write with reg_off==2 loads wdata[15:0]. A press event in the same cycle is added to the loaded value.
- Read map (upper bits zero):
  - STATUS = {0, key_level}
  - EVENTS = {0, events}
  - COUNT = {16'b0, count}
  - SWITCH = {0, sw_level}
- Writes to STATUS and SWITCH are ignored. Reads have no side effects.
- Reset asserted mid-debounce: the counter is discarded; after release, debounce restarts from the reset values.

Decomposition:
- Shared package io_pkg:
  - register offset constants REG_STATUS=0, REG_EVENTS=1, REG_COUNT=2, REG_SWITCH=3.
  - Base I/O address constants used by the top decode.
- Sub-module debounce_cell:
  - Parameter DEBOUNCE_CYCLES and RESET_VAL.
  - Contains the 2-flop synchroniser, the counter and the stable flop; outputs stable.
  - Instantiated once per key and per switch via generate.
- Top-level block holds the edge detect, EVENTS, COUNT and the read mux.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset, then read every offset -> STATUS=0, EVENTS=0, COUNT=0, SWITCH=0, event_pending=0.
- key_raw[1] 1->0, held -> STATUS=0x2 exactly 6 edges later; EVENTS=0x2; COUNT=1; event_pending=1. Releasing the key leaves EVENTS=0x2.
- key_raw[0] pulses low for 3 cycles, then back high -> STATUS, EVENTS and COUNT unchanged. A 4-cycle pulse (post-sync) -> EVENTS bit0 set.
- EVENTS=0x3, write 0x1 to offset 1 -> EVENTS=0x2. Next, a key2 press lands on the same edge as a write of 0x4 -> EVENTS=0x6 (set wins).
- COUNT loaded with 0xFFFF, then keys 0 and 3 pressed on the same cycle -> COUNT=0x0001.
- sw_raw=0x2A5 applied -> SWITCH reads 0x2A5 after 6 edges. Writes to offsets 0 and 3 change nothing. reset pulled low mid-debounce -> all outputs 0 immediately (asynchronous).
